// File: rtl/milano_dmem_slave.sv
// LSU data-memory responder: word-array scratchpad with fixed-latency, in-order load/store responses.
// Optional store byte-enable legality check enabled by defining MILANO_DMEM_BE_CHECK_EN.
module milano_dmem_slave #(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = 4;
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
   localparam logic [29:0]   DEPTH_W  = 30'(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

   typedef struct packed {
      logic          we;
      logic [3:0]    be;
      logic [AW-1:0] idx;
      logic [31:0]   wdata;
      logic          err;
   } req_t;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   req_t          req_q, req_new;
   logic [31:0]   mem [DEPTH];
   logic [31:0]   rdata_q, rd_word;
   logic          err_q;
   logic          hs, oor, be_bad, resp;
   logic          unused_addr;

   assign unused_addr = ^data_addr_i[1:0];
   assign hs          = data_gnt_o & data_req_i;
   assign resp        = (state_q == ST_RESP);
   assign oor         = (data_addr_i[31:2] >= DEPTH_W);

`ifdef MILANO_DMEM_BE_CHECK_EN
   // Only naturally aligned byte, halfword and word stores are legal.
   always_comb begin
      be_bad = 1'b0;
      case (data_be_i)
         4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b1100, 4'b1111: be_bad = 1'b0;
         default:                   be_bad = data_we_i;
      endcase
   end
`else
   assign be_bad = 1'b0;
`endif

   assign req_new = '{we:    data_we_i,
                      be:    data_be_i,
                      idx:   data_addr_i[AW+1:2],
                      wdata: data_wdata_i,
                      err:   oor | be_bad};

   // Read happens in the response cycle so a store committing on the previous edge is visible.
   assign rd_word = (req_q.we || req_q.err) ? 32'h0 : mem[req_q.idx];

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE, ST_RESP: begin
            if (hs) begin
               cnt_d   = CNT_INIT;
               state_d = (LATENCY > 1) ? ST_WAIT : ST_RESP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = ST_RESP;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      data_gnt_o    = 1'b0;
      data_rvalid_o = 1'b0;
      data_rdata_o  = rdata_q;
      data_err_o    = err_q;
      if (!rst_i && (state_q == ST_IDLE || state_q == ST_RESP)) data_gnt_o = data_req_i;
      if (resp) begin
         data_rvalid_o = 1'b1;
         data_rdata_o  = rd_word;
         data_err_o    = req_q.err;
      end
   end

   // Captured request and response hold registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         req_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (hs) req_q <= req_new;
         if (resp) begin
            rdata_q <= rd_word;
            err_q   <= req_q.err;
         end
      end
   end

   // Store commit on the response edge; memory contents are not reset
   always_ff @(posedge clk_i) begin
      if (resp && req_q.we && !req_q.err) begin
         for (int b = 0; b < 4; b++) begin
            if (req_q.be[b]) mem[req_q.idx][8*b +: 8] <= req_q.wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_milano_dmem_slave.sv
// Directed bench for milano_dmem_slave: LATENCY 1 (vector table), 3 (back-to-back) and 4 (reset mid-store).
module tb_milano_dmem_slave;

`ifdef MILANO_DMEM_BE_CHECK_EN
   localparam bit BE_CHK = 1'b1;
`else
   localparam bit BE_CHK = 1'b0;
`endif

   logic        clk;
   logic        rst    [3];
   logic        req    [3];
   logic        we     [3];
   logic [3:0]  be     [3];
   logic [31:0] addr   [3];
   logic [31:0] wdata  [3];
   logic        gnt    [3];
   logic        rvalid [3];
   logic [31:0] rdata  [3];
   logic        err    [3];

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      milano_dmem_slave #(
         .DEPTH  (1024),
         .LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 4))
      ) u_dut (
         .clk_i        (clk),
         .rst_i        (rst[g]),
         .data_req_i   (req[g]),
         .data_we_i    (we[g]),
         .data_be_i    (be[g]),
         .data_addr_i  (addr[g]),
         .data_wdata_i (wdata[g]),
         .data_gnt_o   (gnt[g]),
         .data_rvalid_o(rvalid[g]),
         .data_rdata_o (rdata[g]),
         .data_err_o   (err[g])
      );
   end

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      string       nm;
   } vec_t;

   vec_t tbl[$];

   function automatic int lat(input int i);
      return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] er, input logic ee, input string nm);
      vec_t v;
      v.we = w; v.be = b; v.addr = a; v.wdata = d; v.exp_rdata = er; v.exp_err = ee; v.nm = nm;
      tbl.push_back(v);
   endtask

   // One complete transaction with bounded waits for grant and response
   task automatic txn(input int i, input logic w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] er, input logic ee, input string nm);
      int n;
      @(negedge clk);
      req[i] = 1'b1; we[i] = w; be[i] = b; addr[i] = a; wdata[i] = d;
      #1;
      n = 0;
      while (!gnt[i] && n < 20) begin
         @(negedge clk); #1; n++;
      end
      chk({nm, "_gnt"}, 32'(gnt[i]), 32'd1);
      @(negedge clk);
      req[i] = 1'b0;
      n = 1;
      while (!rvalid[i] && n < 20) begin
         @(negedge clk); n++;
      end
      chk({nm, "_latency"}, 32'(n), 32'(lat(i)));
      chk({nm, "_rdata"}, rdata[i], er);
      chk({nm, "_err"}, 32'(err[i]), 32'(ee));
   endtask

   initial begin
      int  n;
      bit  seen;
      clk = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; req[i] = 1'b1; we[i] = 1'b0; be[i] = 4'hF; addr[i] = '0; wdata[i] = '0;
      end
      repeat (2) @(negedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_gnt%0d", i), 32'(gnt[i]), 32'd0);
         chk($sformatf("rst_rvalid%0d", i), 32'(rvalid[i]), 32'd0);
         chk($sformatf("rst_rdata%0d", i), rdata[i], 32'h0);
         chk($sformatf("rst_err%0d", i), 32'(err[i]), 32'd0);
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         req[i] = 1'b0; rst[i] = 1'b0;
      end

      // LATENCY=1 vector table
      add(1, 4'hF, 32'h10,   32'hDEADBEEF, 32'h0,        0, "sw_10");
      add(0, 4'hF, 32'h10,   32'h0,        32'hDEADBEEF, 0, "lw_10");
      add(1, 4'hF, 32'h20,   32'h11223344, 32'h0,        0, "sw_20");
      add(1, 4'h4, 32'h22,   32'h00AA0000, 32'h0,        0, "sb_22");
      add(0, 4'hF, 32'h20,   32'h0,        32'h11AA3344, 0, "lw_20");
      add(0, 4'h3, 32'h20,   32'h0,        32'h11AA3344, 0, "lh_20_fullword");
      add(1, 4'hF, 32'h0,    32'hCAFEF00D, 32'h0,        0, "sw_0");
      add(0, 4'hF, 32'h1000, 32'h0,        32'h0,        1, "lw_oor");
      add(1, 4'hF, 32'h1000, 32'hFFFFFFFF, 32'h0,        1, "sw_oor");
      add(0, 4'hF, 32'h0,    32'h0,        32'hCAFEF00D, 0, "lw_0_after_oor");
      add(1, 4'h0, 32'h0,    32'h00000000, 32'h0,        0, "sw_be0");
      add(0, 4'hF, 32'h0,    32'h0,        32'hCAFEF00D, 0, "lw_0_after_be0");
      add(1, 4'hF, 32'hFFC,  32'h12345678, 32'h0,        0, "sw_last");
      add(0, 4'hF, 32'hFFC,  32'h0,        32'h12345678, 0, "lw_last");
      add(1, 4'hF, 32'h30,   32'h01020304, 32'h0,        0, "sw_30");
      add(1, 4'h5, 32'h30,   32'hA0B0C0D0, 32'h0,        BE_CHK, "sw_be0101");
      add(0, 4'hF, 32'h30,   32'h0,        BE_CHK ? 32'h01020304 : 32'h01B003D0, 0, "lw_30_a");
      add(1, 4'hC, 32'h32,   32'h55660000, 32'h0,        0, "sh_32");
      add(0, 4'hF, 32'h33,   32'h0,        BE_CHK ? 32'h55660304 : 32'h556603D0, 0, "lw_33");
      foreach (tbl[k]) txn(0, tbl[k].we, tbl[k].be, tbl[k].addr, tbl[k].wdata,
                           tbl[k].exp_rdata, tbl[k].exp_err, tbl[k].nm);

      // LATENCY=1 back-to-back store, load, store to one word with req held
      @(negedge clk);
      req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h40; wdata[0] = 32'h0BADCAFE;
      #1 chk("b2b_gnt0", 32'(gnt[0]), 32'd1);
      @(negedge clk);
      chk("b2b_st_rvalid", 32'(rvalid[0]), 32'd1);
      chk("b2b_st_err", 32'(err[0]), 32'd0);
      we[0] = 1'b0;
      #1 chk("b2b_gnt1", 32'(gnt[0]), 32'd1);
      @(negedge clk);
      chk("b2b_ld_rvalid", 32'(rvalid[0]), 32'd1);
      chk("b2b_ld_rdata", rdata[0], 32'h0BADCAFE);
      we[0] = 1'b1; wdata[0] = 32'h11111111;
      #1 chk("b2b_ld_rdata_prestore", rdata[0], 32'h0BADCAFE);
      @(negedge clk);
      chk("b2b_st2_rvalid", 32'(rvalid[0]), 32'd1);
      chk("b2b_st2_rdata", rdata[0], 32'h0);
      req[0] = 1'b0;
      @(negedge clk);
      chk("b2b_idle_rvalid", 32'(rvalid[0]), 32'd0);
      txn(0, 1'b0, 4'hF, 32'h40, 32'h0, 32'h11111111, 1'b0, "b2b_lw_after");

      // LATENCY=3 back-to-back loads
      txn(1, 1'b1, 4'hF, 32'h8, 32'hAAAA0001, 32'h0, 1'b0, "l3_sw_8");
      txn(1, 1'b1, 4'hF, 32'hC, 32'hBBBB0002, 32'h0, 1'b0, "l3_sw_c");
      @(negedge clk);
      req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h8;
      #1 chk("l3_gnt_T", 32'(gnt[1]), 32'd1);
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         chk($sformatf("l3_gnt_T%0d", c), 32'(gnt[1]), 32'd0);
         chk($sformatf("l3_rvalid_T%0d", c), 32'(rvalid[1]), 32'd0);
      end
      @(negedge clk);
      chk("l3_rvalid_T3", 32'(rvalid[1]), 32'd1);
      chk("l3_rdata_T3", rdata[1], 32'hAAAA0001);
      chk("l3_gnt_T3", 32'(gnt[1]), 32'd1);
      addr[1] = 32'hC;
      for (int c = 4; c <= 5; c++) begin
         @(negedge clk);
         chk($sformatf("l3_gnt_T%0d", c), 32'(gnt[1]), 32'd0);
      end
      @(negedge clk);
      chk("l3_rvalid_T6", 32'(rvalid[1]), 32'd1);
      chk("l3_rdata_T6", rdata[1], 32'hBBBB0002);
      req[1] = 1'b0;
      @(negedge clk);
      chk("l3_rvalid_T7", 32'(rvalid[1]), 32'd0);
      chk("l3_rdata_hold", rdata[1], 32'hBBBB0002);

      // LATENCY=4 reset one cycle after a store handshake
      txn(2, 1'b1, 4'hF, 32'h4, 32'h600DF00D, 32'h0, 1'b0, "l4_sw_4");
      @(negedge clk);
      req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h4; wdata[2] = 32'hBAD0BAD0;
      #1 chk("l4_gnt_hs", 32'(gnt[2]), 32'd1);
      @(posedge clk);
      @(posedge clk);
      #1 rst[2] = 1'b1;
      #1;
      chk("l4_gnt_in_rst", 32'(gnt[2]), 32'd0);
      chk("l4_rvalid_in_rst", 32'(rvalid[2]), 32'd0);
      @(negedge clk);
      rst[2] = 1'b0; req[2] = 1'b0;
      seen = 1'b0;
      for (n = 0; n < 8; n++) begin
         @(negedge clk);
         if (rvalid[2]) seen = 1'b1;
      end
      chk("l4_no_rvalid_after_rst", 32'(seen), 32'd0);
      txn(2, 1'b0, 4'hF, 32'h4, 32'h0, 32'h600DF00D, 1'b0, "l4_lw_4_old");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
